snow2_keystream_xor: RTL and testbench

- Downstream consumer of the SNOW_2 core.
- Sequences the core's load and initialization phases.
- Discards the keystream words produced during initialization, then buffers valid keystream words in a small FIFO.
- XORs each buffered word with a plaintext word under a valid/ready handshake to produce ciphertext (decryption is identical).

---
 rtl/snow2_keystream_xor.sv | 144 ++++++++++++++
 tb/tb_snow2_keystream_xor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snow2_keystream_xor.sv
// SNOW_2 keystream consumer: sequences core load/init, discards the init
// keystream, buffers run-time keystream words and XORs them with plaintext.
module snow2_keystream_xor #(
    parameter int unsigned INIT_CYCLES = 33,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        core_load,
    output logic        core_en,
    input  logic [31:0] keystream,
    output logic        ready_ks,
    input  logic [31:0] pt_data,
    input  logic        pt_valid,
    output logic        pt_ready,
    output logic [31:0] ct_data,
    output logic        ct_valid,
    input  logic        ct_ready,
    output logic [31:0] words_done
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_RUN
    } state_t;

    state_t             r_state;
    logic [INIT_W-1:0]  r_init_cnt;
    logic [31:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_ct_data;
    logic               r_ct_valid;
    logic [31:0]        r_words_done;

    logic               w_run;
    logic               w_pt_ready;
    logic               w_pop;
    logic               w_core_en;
    logic               w_push;
    logic               w_ct_take;

    // Handshake and core-advance decode; in RUN the core only steps when its
    // word can be stored, so every keystream word lands in the FIFO exactly once.
    always_comb begin
        w_run      = (r_state == S_RUN);
        w_pt_ready = w_run && (r_count != '0) && (!r_ct_valid || ct_ready);
        w_pop      = pt_valid && w_pt_ready;
        w_core_en  = (r_state == S_INIT) ||
                     (w_run && ((r_count < CNT_W'(FIFO_DEPTH)) || w_pop));
        w_push     = w_run && w_core_en;
        w_ct_take  = r_ct_valid && ct_ready;
    end

    // Session sequencer: IDLE -> LOAD -> INIT (INIT_CYCLES enabled edges) -> RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_init_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_init_cnt <= '0;
                    r_state    <= S_INIT;
                end
                S_INIT: begin
                    if (start) begin
                        r_state <= S_LOAD;
                    end else if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                        r_state <= S_RUN;
                    end else begin
                        r_init_cnt <= r_init_cnt + INIT_W'(1);
                    end
                end
                S_RUN: begin
                    if (start) r_state <= S_LOAD;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; flushed while the core is being loaded.
    always_ff @(posedge clk) begin
        if (!rst_n || r_state == S_LOAD) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    // Keystream storage; a full FIFO may overwrite the head slot only while
    // that head is being read out on the same edge.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= keystream;
    end

    // Ciphertext register and handoff counter; a restart drops any pending word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ct_data    <= '0;
            r_ct_valid   <= 1'b0;
            r_words_done <= '0;
        end else if (r_state == S_LOAD) begin
            r_ct_valid   <= 1'b0;
            r_words_done <= '0;
        end else if (start && (r_state == S_INIT || r_state == S_RUN)) begin
            r_ct_valid   <= 1'b0;
        end else begin
            if (w_ct_take) r_words_done <= r_words_done + 32'd1;
            if (w_pop) begin
                r_ct_data  <= pt_data ^ r_mem[r_rd_ptr];
                r_ct_valid <= 1'b1;
            end else if (w_ct_take) begin
                r_ct_valid <= 1'b0;
            end
        end
    end

    assign core_load  = (r_state == S_LOAD);
    assign core_en    = w_core_en;
    assign ready_ks   = w_run;
    assign pt_ready   = w_pt_ready;
    assign ct_data    = r_ct_data;
    assign ct_valid   = r_ct_valid;
    assign words_done = r_words_done;

endmodule

// File: tb/tb_snow2_keystream_xor.sv
// Self-checking bench for snow2_keystream_xor with a stub SNOW_2 core and a
// scoreboard built from the rule "k-th accepted word XOR k-th post-init word".
module tb_snow2_keystream_xor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        core_load;
    logic        core_en;
    logic [31:0] keystream;
    logic        ready_ks;
    logic [31:0] pt_data;
    logic        pt_valid;
    logic        pt_ready;
    logic [31:0] ct_data;
    logic        ct_valid;
    logic        ct_ready;
    logic [31:0] words_done;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Scoreboard state
    logic [31:0] q[$];
    int unsigned k;
    int unsigned m_done;
    bit          acc;
    bit          p_stall;
    logic [31:0] p_data;
    int unsigned cyc;

    // Stub core: word = 0xA0000000 + core_en edges since core_load
    logic [31:0] ks_n = '0;

    snow2_keystream_xor #(.INIT_CYCLES(33), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .core_load  (core_load),
        .core_en    (core_en),
        .keystream  (keystream),
        .ready_ks   (ready_ks),
        .pt_data    (pt_data),
        .pt_valid   (pt_valid),
        .pt_ready   (pt_ready),
        .ct_data    (ct_data),
        .ct_valid   (ct_valid),
        .ct_ready   (ct_ready),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

    // Stub core stepping
    always @(posedge clk) begin
        if (core_load)    ks_n <= '0;
        else if (core_en) ks_n <= ks_n + 32'd1;
    end
    assign keystream = 32'hA000_0000 + ks_n;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_reset();
        q.delete();
        k       = 0;
        m_done  = 0;
        acc     = 1'b0;
        p_stall = 1'b0;
    endtask

    // Observes handshakes mid-cycle and checks against the scoreboard
    task automatic monitor();
        if (rst_n) begin
            if (ct_valid && ct_ready) begin
                if (q.size() == 0) chk_eq("ct_unexpected", {31'd0, ct_valid}, 32'd0);
                else               chk_eq("ct_data", ct_data, q.pop_front());
                m_done++;
            end
            if (acc) chk_eq("ct_latency", {31'd0, ct_valid}, 32'd1);
            if (p_stall && ct_valid) chk_eq("ct_hold", ct_data, p_data);
            if (ct_valid && !ct_ready) chk_eq("pt_ready_stall", {31'd0, pt_ready}, 32'd0);
            p_stall = ct_valid && !ct_ready;
            p_data  = ct_data;
            if (pt_valid && pt_ready) begin
                q.push_back(pt_data ^ (32'hA000_0021 + k));
                k++;
                acc = 1'b1;
            end else begin
                acc = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [31:0] d);
        bit done;
        done     = 1'b0;
        pt_data  = d;
        pt_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            step();
            if (acc) done = 1'b1;
        end
        if (!done) chk_eq("send_timeout", {31'd0, pt_ready}, 32'd1);
    endtask

    task automatic run_init();
        int unsigned nload;
        int unsigned nen;
        pt_valid = 1'b0;
        start    = 1'b1;
        step();
        start    = 1'b0;
        sb_reset();
        chk_eq("load_ct_valid", {31'd0, ct_valid}, 32'd0);
        nload = 0;
        nen   = 0;
        for (int i = 0; i < 100 && !ready_ks; i++) begin
            if (core_load) nload++;
            if (core_en)   nen++;
            step();
        end
        chk_eq("init_ready", {31'd0, ready_ks}, 32'd1);
        chk_eq("init_load_cycles", nload, 32'd1);
        chk_eq("init_en_cycles", nen, 32'd33);
        chk_eq("init_words_done", words_done, 32'd0);
    endtask

    initial begin
        int unsigned c0;
        int unsigned nacc;
        cyc      = 0;
        sb_reset();
        rst_n    = 1'b0;
        start    = 1'b1;
        pt_data  = '0;
        pt_valid = 1'b0;
        ct_ready = 1'b0;

        // Scenario 1: reset held with start asserted
        for (int i = 0; i < 3; i++) begin
            step();
            chk_eq("rst_core_load", {31'd0, core_load}, 32'd0);
            chk_eq("rst_core_en",   {31'd0, core_en},   32'd0);
            chk_eq("rst_ready_ks",  {31'd0, ready_ks},  32'd0);
            chk_eq("rst_pt_ready",  {31'd0, pt_ready},  32'd0);
            chk_eq("rst_ct_valid",  {31'd0, ct_valid},  32'd0);
            chk_eq("rst_ct_data",   ct_data,            32'd0);
            chk_eq("rst_words_done", words_done,        32'd0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        step();
        chk_eq("idle_core_en", {31'd0, core_en}, 32'd0);

        // Scenario 2: init sequencing
        run_init();

        // Scenario 3: streaming, back-to-back with FIFO primed
        ct_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        c0 = cyc;
        send(32'h0000_0000);
        send(32'hFFFF_FFFF);
        send(32'h1234_5678);
        chk_eq("s3_cycles", cyc - c0, 32'd3);
        pt_valid = 1'b0;
        step();
        step();
        chk_eq("s3_words_done", words_done, 32'd3);
        chk_eq("s3_ct_valid", {31'd0, ct_valid}, 32'd0);

        // Scenario 4: backpressure
        ct_ready = 1'b0;
        pt_valid = 1'b1;
        pt_data  = $urandom;
        nacc     = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (acc) begin
                nacc++;
                pt_data = $urandom;
            end
        end
        chk_eq("s4_accepts", nacc, 32'd1);
        chk_eq("s4_core_en_full", {31'd0, core_en}, 32'd0);
        chk_eq("s4_pt_ready", {31'd0, pt_ready}, 32'd0);
        ct_ready = 1'b1;
        send(pt_data);
        send($urandom);
        pt_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk_eq("s4_words_done", words_done, m_done);

        // Scenario 5: restart mid-RUN with a pending ct word
        ct_ready = 1'b0;
        send($urandom);
        pt_valid = 1'b0;
        step();
        chk_eq("s5_pending", {31'd0, ct_valid}, 32'd1);
        run_init();
        ct_ready = 1'b1;
        send($urandom);
        send($urandom);
        pt_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk_eq("s5_words_done", words_done, 32'd2);

        // Scenario 6: reset in the middle of INIT
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk_eq("s6_in_init", {31'd0, core_en}, 32'd1);
        rst_n = 1'b0;
        step();
        chk_eq("s6_core_en",   {31'd0, core_en},   32'd0);
        chk_eq("s6_core_load", {31'd0, core_load}, 32'd0);
        chk_eq("s6_ready_ks",  {31'd0, ready_ks},  32'd0);
        rst_n = 1'b1;
        sb_reset();
        step();
        chk_eq("s6_idle_en", {31'd0, core_en}, 32'd0);
        run_init();

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            pt_valid = 1'($urandom_range(0, 1));
            pt_data  = $urandom;
            ct_ready = 1'($urandom_range(0, 1));
            step();
        end
        pt_valid = 1'b0;
        ct_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk_eq("rand_words_done", words_done, m_done);
        chk_eq("rand_sb_drained", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
